// File: rtl/load_attributes_consumer.sv
// rtl/load_attributes_consumer.sv - read end of the load-attributes FIFO, pairs memory responses with load attributes
//
// Purpose:
//   Pairs each returning memory read response with the head entry of the
//   load-attributes FIFO. The loaded word is aligned and sign- or zero-extended,
//   then presented as a registered writeback result with a valid/ack handshake.
//   Memory responses cannot be stalled, so a 2-entry response buffer absorbs
//   writeback backpressure.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   attr_valid      head attribute entry valid
//   attr_fn3        load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//   attr_byte_addr  address bits [1:0] of the head load
//   attr_id         ID of the head load
//   attr_pop        pop strobe to the attributes FIFO (combinational)
//   mem_rvalid      memory read response valid (no backpressure)
//   mem_rdata       raw memory word
//   resp_count      response buffer occupancy (0..2)
//   wb_valid        writeback result valid
//   wb_ack          writeback accepted
//   wb_data         formatted load result
//   wb_id           ID of the result
//   overflow_error  sticky: a response was dropped because the buffer was full
//   orphan_error    sticky: a response was present with no attribute available

module load_attributes_consumer #(
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  attr_valid,
   input  logic [2:0]            attr_fn3,
   input  logic [1:0]            attr_byte_addr,
   input  logic [ID_WIDTH-1:0]   attr_id,
   output logic                  attr_pop,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [1:0]            resp_count,
   output logic                  wb_valid,
   input  logic                  wb_ack,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [ID_WIDTH-1:0]   wb_id,
   output logic                  overflow_error,
   output logic                  orphan_error
);

   logic [DATA_WIDTH-1:0] resp_mem [2];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            count;

   logic                  reg_free;
   logic                  buf_nonempty;
   logic                  src_avail;
   logic                  pair;
   logic                  deq;
   logic                  bypass;
   logic                  enq;
   logic                  drop;
   logic [DATA_WIDTH-1:0] src_data;
   logic [DATA_WIDTH-1:0] fmt_data;

   function automatic logic [DATA_WIDTH-1:0] format_load(
      input logic [2:0]            fn3,
      input logic [1:0]            byte_addr,
      input logic [DATA_WIDTH-1:0] raw
   );
      logic [DATA_WIDTH-1:0] shifted;
      shifted = raw >> {byte_addr, 3'b000};
      case (fn3)
         3'b000:  format_load = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b100:  format_load = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'b001:  format_load = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b101:  format_load = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: format_load = raw;   // LW and undefined codes pass the word through
      endcase
   endfunction

   assign reg_free     = !wb_valid || wb_ack;
   assign buf_nonempty = (count != 2'd0);
   // Buffered responses are older than anything on the bus, so the head always wins.
   assign src_avail    = buf_nonempty || mem_rvalid;
   assign pair         = attr_valid && reg_free && src_avail && !rst;
   assign deq          = pair && buf_nonempty;
   assign bypass       = pair && !buf_nonempty;
   // A full buffer can still accept when its head leaves in the same cycle.
   assign enq          = mem_rvalid && !bypass && ((count != 2'd2) || deq);
   assign drop         = mem_rvalid && (count == 2'd2) && !deq;
   assign src_data     = buf_nonempty ? resp_mem[rd_ptr] : mem_rdata;
   assign fmt_data     = format_load(attr_fn3, attr_byte_addr, src_data);

   assign attr_pop   = pair;
   assign resp_count = count;

   always_ff @(posedge clk) begin
      if (enq) begin
         resp_mem[wr_ptr] <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr         <= 1'b0;
         wr_ptr         <= 1'b0;
         count          <= 2'd0;
         wb_valid       <= 1'b0;
         wb_data        <= '0;
         wb_id          <= '0;
         overflow_error <= 1'b0;
         orphan_error   <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, enq} - {1'b0, deq};

         if (pair) begin
            wb_valid <= 1'b1;
            wb_data  <= fmt_data;
            wb_id    <= attr_id;
         end else if (wb_ack) begin
            wb_valid <= 1'b0;
         end

         if (drop) begin
            overflow_error <= 1'b1;
         end
         if (src_avail && !attr_valid) begin
            orphan_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_load_attributes_consumer.sv
// tb/tb_load_attributes_consumer.sv - self-checking bench for load_attributes_consumer
module tb_load_attributes_consumer;

   logic        clk = 1'b0;
   logic        rst;
   logic        attr_valid;
   logic [2:0]  attr_fn3;
   logic [1:0]  attr_byte_addr;
   logic [1:0]  attr_id;
   logic        attr_pop;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [1:0]  resp_count;
   logic        wb_valid;
   logic        wb_ack;
   logic [31:0] wb_data;
   logic [1:0]  wb_id;
   logic        overflow_error;
   logic        orphan_error;

   always #5 clk = ~clk;

   load_attributes_consumer #(.ID_WIDTH(2), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .attr_valid(attr_valid), .attr_fn3(attr_fn3), .attr_byte_addr(attr_byte_addr),
      .attr_id(attr_id), .attr_pop(attr_pop),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .resp_count(resp_count),
      .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_data(wb_data), .wb_id(wb_id),
      .overflow_error(overflow_error), .orphan_error(orphan_error)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: response queue, output register, sticky flags, attribute FIFO head id.
   logic [31:0] m_q[$];
   logic        m_wbv;
   logic [31:0] m_wbd;
   logic [1:0]  m_wbid;
   logic        m_ovf;
   logic        m_orph;
   logic [1:0]  head_id;
   logic        got_pop;
   logic        exp_pop;

   function automatic logic [31:0] ref_fmt(input logic [2:0] f, input logic [1:0] ba, input logic [31:0] d);
      logic [31:0] sh;
      logic [31:0] b;
      logic [31:0] h;
      sh = d >> (8 * ba);
      b  = sh % 256;
      h  = sh % 65536;
      case (f)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_wbv = 0; m_wbd = 0; m_wbid = 0; m_ovf = 0; m_orph = 0; head_id = 0;
   endfunction

   function automatic void model_step(input logic av, input logic [2:0] f, input logic [1:0] ba,
                                      input logic rv, input logic [31:0] rd, input logic ack);
      logic free;
      logic src;
      logic [31:0] d;
      free = !m_wbv || ack;
      src  = (m_q.size() > 0) || rv;
      exp_pop = av && free && src;
      if (src && !av) m_orph = 1;
      if (exp_pop) begin
         if (m_q.size() > 0) begin
            d = m_q.pop_front();
            if (rv) m_q.push_back(rd);
         end else begin
            d = rd;
         end
         m_wbv = 1; m_wbd = ref_fmt(f, ba, d); m_wbid = head_id;
         head_id = head_id + 2'd1;
      end else begin
         if (rv) begin
            if (m_q.size() < 2) m_q.push_back(rd);
            else m_ovf = 1;
         end
         if (ack) m_wbv = 0;
      end
   endfunction

   // Drives one cycle of inputs, samples the combinational pop, advances the model and the clock.
   task automatic cycle(input logic av, input logic [2:0] f, input logic [1:0] ba,
                        input logic rv, input logic [31:0] rd, input logic ack);
      attr_valid = av; attr_fn3 = f; attr_byte_addr = ba; attr_id = head_id;
      mem_rvalid = rv; mem_rdata = rd; wb_ack = ack;
      #1;
      got_pop = attr_pop;
      model_step(av, f, ba, rv, rd, ack);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      attr_valid = 0; attr_fn3 = 0; attr_byte_addr = 0; attr_id = 0;
      mem_rvalid = 0; mem_rdata = 0; wb_ack = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      attr_valid = 1; attr_fn3 = 3'b010; attr_byte_addr = 0; attr_id = 0;
      mem_rvalid = 1; mem_rdata = 32'h12345678; wb_ack = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if ({resp_count, wb_valid, wb_id, overflow_error, orphan_error, attr_pop} !== 8'd0) begin
         n_bad++; $display("FAIL reset_ctrl got cnt=%0d v=%b id=%0d ovf=%b orph=%b pop=%b exp all 0",
                           resp_count, wb_valid, wb_id, overflow_error, orphan_error, attr_pop);
      end
      n_cmp++; if (wb_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_data got %h exp 00000000", wb_data);
      end
      rst = 0;
      model_reset();
      attr_valid = 0; mem_rvalid = 0;
   endtask

   task automatic test_bypass_lw();
      apply_reset();
      head_id = 2'd1;
      cycle(1, 3'b010, 2'd0, 1, 32'hDEADBEEF, 1);
      n_cmp++; if (got_pop !== 1'b1) begin
         n_bad++; $display("FAIL bypass_pop got %b exp 1", got_pop);
      end
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_id !== 2'd1) begin
         n_bad++; $display("FAIL bypass_wb got v=%b d=%h id=%0d exp v=1 d=deadbeef id=1", wb_valid, wb_data, wb_id);
      end
      n_cmp++; if (resp_count !== 2'd0) begin
         n_bad++; $display("FAIL bypass_count got %0d exp 0", resp_count);
      end
   endtask

   task automatic test_extension();
      logic [2:0]  fns [4];
      logic [31:0] dat [4];
      logic [31:0] exp [4];
      fns[0] = 3'b000; dat[0] = 32'h1280FF00; exp[0] = 32'hFFFFFF80;
      fns[1] = 3'b100; dat[1] = 32'h1280FF00; exp[1] = 32'h00000080;
      fns[2] = 3'b001; dat[2] = 32'h80010000; exp[2] = 32'hFFFF8001;
      fns[3] = 3'b101; dat[3] = 32'h80010000; exp[3] = 32'h00008001;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1, fns[i], 2'd2, 1, dat[i], 1);
         n_cmp++; if (wb_valid !== 1'b1 || wb_data !== exp[i]) begin
            n_bad++; $display("FAIL extension_%0d got v=%b d=%h exp v=1 d=%h", i, wb_valid, wb_data, exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      cycle(1, 3'b010, 0, 1, 32'hAAAA0000, 0);
      cycle(1, 3'b010, 0, 1, 32'hBBBB1111, 0);
      cycle(1, 3'b010, 0, 1, 32'hCCCC2222, 0);
      n_cmp++; if (resp_count !== 2'd2 || overflow_error !== 1'b0) begin
         n_bad++; $display("FAIL bp_full got cnt=%0d ovf=%b exp cnt=2 ovf=0", resp_count, overflow_error);
      end
      cycle(1, 3'b010, 0, 1, 32'hDDDD3333, 0);
      n_cmp++; if (overflow_error !== 1'b1 || resp_count !== 2'd2) begin
         n_bad++; $display("FAIL bp_overflow got ovf=%b cnt=%0d exp ovf=1 cnt=2", overflow_error, resp_count);
      end
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA0000 || wb_id !== 2'd0) begin
         n_bad++; $display("FAIL bp_hold got v=%b d=%h id=%0d exp v=1 d=aaaa0000 id=0", wb_valid, wb_data, wb_id);
      end
      cycle(1, 3'b010, 0, 0, 0, 1);
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB1111 || wb_id !== 2'd1) begin
         n_bad++; $display("FAIL bp_drain_b got v=%b d=%h id=%0d exp v=1 d=bbbb1111 id=1", wb_valid, wb_data, wb_id);
      end
      cycle(1, 3'b010, 0, 0, 0, 1);
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hCCCC2222 || wb_id !== 2'd2 || resp_count !== 2'd0) begin
         n_bad++; $display("FAIL bp_drain_c got v=%b d=%h id=%0d cnt=%0d exp v=1 d=cccc2222 id=2 cnt=0",
                           wb_valid, wb_data, wb_id, resp_count);
      end
   endtask

   task automatic test_simul_enq_deq();
      apply_reset();
      cycle(1, 3'b010, 0, 1, 32'h00000001, 0);
      cycle(1, 3'b010, 0, 1, 32'h00000002, 0);
      cycle(1, 3'b010, 0, 1, 32'h00000003, 0);
      cycle(1, 3'b010, 0, 1, 32'h00000004, 1);
      n_cmp++; if (resp_count !== 2'd2 || overflow_error !== 1'b0 || wb_data !== 32'h2) begin
         n_bad++; $display("FAIL simul got cnt=%0d ovf=%b d=%h exp cnt=2 ovf=0 d=00000002", resp_count, overflow_error, wb_data);
      end
      for (int i = 3; i <= 4; i++) begin
         cycle(1, 3'b010, 0, 0, 0, 1);
         n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'(i)) begin
            n_bad++; $display("FAIL simul_order_%0d got v=%b d=%h exp v=1 d=%h", i, wb_valid, wb_data, 32'(i));
         end
      end
   endtask

   task automatic test_orphan();
      apply_reset();
      cycle(0, 3'b010, 0, 1, 32'hCAFEF00D, 0);
      n_cmp++; if (orphan_error !== 1'b1 || resp_count !== 2'd1) begin
         n_bad++; $display("FAIL orphan_flag got orph=%b cnt=%0d exp orph=1 cnt=1", orphan_error, resp_count);
      end
      cycle(0, 3'b010, 0, 0, 0, 0);
      cycle(0, 3'b010, 0, 0, 0, 0);
      cycle(1, 3'b010, 0, 0, 0, 0);
      n_cmp++; if (got_pop !== 1'b1) begin
         n_bad++; $display("FAIL orphan_pop got %b exp 1", got_pop);
      end
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || resp_count !== 2'd0) begin
         n_bad++; $display("FAIL orphan_wb got v=%b d=%h cnt=%0d exp v=1 d=cafef00d cnt=0", wb_valid, wb_data, resp_count);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      cycle(1, 3'b010, 0, 1, 32'h11111111, 0);
      cycle(1, 3'b010, 0, 1, 32'h22222222, 0);
      cycle(1, 3'b010, 0, 1, 32'h33333333, 0);
      attr_valid = 1; mem_rvalid = 1; wb_ack = 1;
      #2 rst = 1;
      #1;
      n_cmp++; if ({resp_count, wb_valid, wb_id, overflow_error, orphan_error, attr_pop} !== 8'd0 || wb_data !== 32'h0) begin
         n_bad++; $display("FAIL async_reset got cnt=%0d v=%b d=%h id=%0d pop=%b exp all 0",
                           resp_count, wb_valid, wb_data, wb_id, attr_pop);
      end
      @(posedge clk);
      #1 rst = 0;
      model_reset();
      cycle(1, 3'b000, 2'd3, 1, 32'h80000000, 1);
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFF80 || resp_count !== 2'd0) begin
         n_bad++; $display("FAIL async_after got v=%b d=%h cnt=%0d exp v=1 d=ffffff80 cnt=0", wb_valid, wb_data, resp_count);
      end
   endtask

   task automatic test_random();
      logic [2:0] fsel [8];
      fsel[0] = 3'b000; fsel[1] = 3'b001; fsel[2] = 3'b010; fsel[3] = 3'b100;
      fsel[4] = 3'b101; fsel[5] = 3'b011; fsel[6] = 3'b110; fsel[7] = 3'b111;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 9) < 7), fsel[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 9) < 6));
         n_cmp++; if (got_pop !== exp_pop || wb_valid !== m_wbv || wb_data !== m_wbd || wb_id !== m_wbid) begin
            n_bad++; $display("FAIL rand_wb_%0d got pop=%b v=%b d=%h id=%0d exp pop=%b v=%b d=%h id=%0d",
                              i, got_pop, wb_valid, wb_data, wb_id, exp_pop, m_wbv, m_wbd, m_wbid);
         end
         n_cmp++; if (resp_count !== 2'(m_q.size()) || overflow_error !== m_ovf || orphan_error !== m_orph) begin
            n_bad++; $display("FAIL rand_state_%0d got cnt=%0d ovf=%b orph=%b exp cnt=%0d ovf=%b orph=%b",
                              i, resp_count, overflow_error, orphan_error, m_q.size(), m_ovf, m_orph);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass_lw();
      test_extension();
      test_backpressure();
      test_simul_enq_deq();
      test_orphan();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
